// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART: register offsets, STATUS bit
// positions, the serial engine state type and a bit-timing helper.
package apb_uart_pkg;

    // Register select values, taken from PADDR[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    // STATUS register bit positions
    localparam int unsigned ST_TX_FULL     = 0;
    localparam int unsigned ST_TX_EMPTY    = 1;
    localparam int unsigned ST_TX_BUSY     = 2;
    localparam int unsigned ST_RX_VALID    = 3;
    localparam int unsigned ST_RX_OVERRUN  = 4;
    localparam int unsigned ST_TX_OVERFLOW = 5;
    localparam int unsigned ST_FRAME_ERR   = 6;
    localparam int unsigned ST_WIDTH       = 7;

    // Frame position, used by both the transmitter and the receiver
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Terminal count of the half-bit wait: ((div + 1) >> 1) - 1
    function automatic logic [15:0] half_bit_m1(input logic [15:0] div);
        logic [16:0] period;
        logic [16:0] half;
        period = {1'b0, div} + 17'd1;
        half   = period >> 1;
        return half[15:0] - 16'd1;
    endfunction

endpackage

// File: rtl/apb_uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter. A push while full is
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart.sv
// APB completer for an 8N1 UART: TX FIFO + transmitter, receiver with a
// single holding register, STATUS flags and a level interrupt.
module apb_uart
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [3:0]            PBE,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic                  irq
);

    // ---------------- APB decode ----------------
    logic       access;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] reg_sel;
    logic       tx_push_req;
    logic       rx_read;
    logic       status_wr;
    logic       baud_wr;
    logic       unused_bits;

    assign access      = PSEL & PENABLE;
    assign PREADY      = access;
    assign wr_en       = access & PWRITE;
    assign rd_en       = access & ~PWRITE;
    assign reg_sel     = PADDR[3:2];
    assign tx_push_req = wr_en & (reg_sel == REG_TXDATA) & PBE[0];
    assign rx_read     = rd_en & (reg_sel == REG_RXDATA);
    assign status_wr   = wr_en & (reg_sel == REG_STATUS) & PBE[0];
    assign baud_wr     = wr_en & (reg_sel == REG_BAUDDIV);
    assign unused_bits = &{1'b0, PADDR[ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:16], PBE[3:2]};

    // ---------------- registers and flags ----------------
    logic [15:0] baud_div;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_overrun;
    logic        tx_overflow;
    logic        frame_err;

    // ---------------- TX FIFO ----------------
    logic       tx_pop;
    logic [7:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (tx_push_req),
        .pop   (tx_pop),
        .wdata (PWDATA[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- TX engine ----------------
    uart_state_t tx_state, tx_state_next;
    logic [15:0] tx_cnt, tx_cnt_next;
    logic [15:0] tx_div, tx_div_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic [7:0]  tx_shift, tx_shift_next;
    logic        tx_line, tx_line_next;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div);
    assign uart_tx    = tx_line;

    // TX state and datapath registers; the line is registered from the state
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= DEFAULT_DIV;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_div   <= tx_div_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx_line  <= tx_line_next;
        end
    end

    // TX next-state: bit timing, FIFO pops and serial line level
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + 16'd1;
        tx_div_next   = tx_div;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_pop        = 1'b0;
        tx_line_next  = 1'b1;

        case (tx_state)
            START:   tx_line_next = 1'b0;
            DATA:    tx_line_next = tx_shift[0];
            default: tx_line_next = 1'b1;
        endcase

        case (tx_state)
            IDLE: begin
                tx_cnt_next = '0;
                if (!fifo_empty) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = fifo_rdata;
                    tx_div_next   = baud_div;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_div_next   = baud_div;
                    tx_bit_next   = '0;
                    tx_state_next = DATA;
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_div_next   = baud_div;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_next = STOP;
                    end else begin
                        tx_bit_next = tx_bit + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_next = '0;
                    tx_div_next = baud_div;
                    if (!fifo_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = fifo_rdata;
                        tx_state_next = START;
                    end else begin
                        tx_state_next = IDLE;
                    end
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    // ---------------- RX engine ----------------
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_fall;
    uart_state_t rx_state, rx_state_next;
    logic [15:0] rx_cnt, rx_cnt_next;
    logic [15:0] rx_div, rx_div_next;
    logic [2:0]  rx_bit, rx_bit_next;
    logic [7:0]  rx_shift, rx_shift_next;
    logic        rx_stop_ok;
    logic        rx_stop_bad;

    assign rx_fall = rx_prev & ~rx_sync;

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state and datapath registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= DEFAULT_DIV;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_div   <= rx_div_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
        end
    end

    // RX next-state: half-bit start check, then mid-bit sampling
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt + 16'd1;
        rx_div_next   = rx_div;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_stop_ok    = 1'b0;
        rx_stop_bad   = 1'b0;

        case (rx_state)
            IDLE: begin
                rx_cnt_next = '0;
                if (rx_fall) begin
                    rx_div_next   = baud_div;
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_cnt == half_bit_m1(rx_div)) begin
                    rx_cnt_next = '0;
                    if (rx_sync) begin
                        rx_state_next = IDLE;
                    end else begin
                        rx_div_next   = baud_div;
                        rx_bit_next   = '0;
                        rx_state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_next   = '0;
                    rx_div_next   = baud_div;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_next = STOP;
                    end else begin
                        rx_bit_next = rx_bit + 3'd1;
                    end
                end
            end
            STOP: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_next   = '0;
                    rx_state_next = IDLE;
                    rx_stop_ok    = rx_sync;
                    rx_stop_bad   = ~rx_sync;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    // ---------------- register file ----------------

    // BAUDDIV, byte-writable in its low two bytes
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            baud_div <= DEFAULT_DIV;
        end else if (baud_wr) begin
            if (PBE[0]) baud_div[7:0]  <= PWDATA[7:0];
            if (PBE[1]) baud_div[15:8] <= PWDATA[15:8];
        end
    end

    // Receive holding register and sticky flags; a set beats a same-cycle clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
            irq         <= 1'b0;
        end else begin
            // a read retiring the held byte frees the slot for a byte landing now
            if (rx_stop_ok && (!rx_valid || rx_read)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end

            if (rx_stop_ok && rx_valid && !rx_read) begin
                rx_overrun <= 1'b1;
            end else if (status_wr && PWDATA[ST_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end

            if (rx_stop_bad) begin
                frame_err <= 1'b1;
            end else if (status_wr && PWDATA[ST_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end

            if (tx_push_req && fifo_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end else if (status_wr && PWDATA[ST_TX_OVERFLOW]) begin
                tx_overflow <= 1'b0;
            end

            irq <= rx_valid | rx_overrun | frame_err;
        end
    end

    // STATUS assembly and read mux
    logic [ST_WIDTH-1:0] status_bits;

    always_comb begin
        status_bits                 = '0;
        status_bits[ST_TX_FULL]     = fifo_full;
        status_bits[ST_TX_EMPTY]    = fifo_empty;
        status_bits[ST_TX_BUSY]     = (tx_state != IDLE);
        status_bits[ST_RX_VALID]    = rx_valid;
        status_bits[ST_RX_OVERRUN]  = rx_overrun;
        status_bits[ST_TX_OVERFLOW] = tx_overflow;
        status_bits[ST_FRAME_ERR]   = frame_err;
    end

    // Read data is only driven during the access phase
    always_comb begin
        PRDATA = '0;
        if (access) begin
            case (reg_sel)
                REG_RXDATA:  PRDATA = {24'b0, rx_byte};
                REG_STATUS:  PRDATA = {{(32 - ST_WIDTH){1'b0}}, status_bits};
                REG_BAUDDIV: PRDATA = {16'b0, baud_div};
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart.sv
// Self-checking bench for apb_uart: APB register accesses, serial TX frame
// decoding and RX frame injection, with expected values queued up front.
module tb_apb_uart;
    import apb_uart_pkg::*;

    localparam logic [31:0] A_TX    = 32'h4000_D000;
    localparam logic [31:0] A_RX    = 32'h4000_D004;
    localparam logic [31:0] A_ST    = 32'h4000_D008;
    localparam logic [31:0] A_BD    = 32'h4000_D00C;
    localparam logic [31:0] A_BD_AL = 32'h4000_DFFC;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [3:0]  PBE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        uart_tx;
    logic        uart_rx;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  got_tx[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx[$];
    logic [31:0] exp_rd[$];

    apb_uart #(
        .ADDR_WIDTH  (32),
        .TX_DEPTH    (4),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PBE     (PBE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx),
        .irq     (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Decodes 4-clock-per-bit frames on uart_tx into {stop, data}
    initial begin : tx_monitor
        logic [8:0] fr;
        fr = '0;
        forever begin
            @(negedge PCLK);
            if (uart_tx === 1'b0) begin
                repeat (2) @(negedge PCLK);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 9; i++) begin
                        repeat (4) @(negedge PCLK);
                        fr[i] = uart_tx;
                    end
                    got_tx.push_back(fr);
                end
            end
        end
    end

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PBE = be;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PBE = 4'h0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #3 data = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(posedge PCLK); #1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (4) @(posedge PCLK);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] rd, exp;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PBE = '0; PWDATA = '0; uart_rx = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL reset_pready: got %b expected 0", PREADY); end
        n_cmp++; if (PRDATA !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h expected 0", PRDATA); end
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL reset_status: got %h expected %h", rd, exp); end
        exp_rd.push_back(32'h0000_0363);
        apb_read(A_BD, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL reset_bauddiv: got %h expected %h", rd, exp); end
        exp_rd.push_back(32'h0000_0363);
        apb_read(A_BD_AL, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL reset_bauddiv_alias: got %h expected %h", rd, exp); end
    endtask

    task automatic test_tx;
        logic [31:0] rd, exp;
        logic        exp_line;
        logic [8:0]  fr;
        logic [7:0]  eb;
        int          t;
        apb_write(A_BD, 32'h0000_0003, 4'b0011);
        exp_rd.push_back(32'h0000_0003);
        apb_read(A_BD, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL tx_bauddiv: got %h expected %h", rd, exp); end
        exp_tx.push_back(8'hA5);
        apb_write(A_TX, 32'h0000_00A5, 4'b0001);
        // now 1ns past the write-completing edge E0
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                @(posedge PCLK); #1;
            end
            exp_line = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
            n_cmp++;
            if (uart_tx !== exp_line) begin
                n_err++; $display("FAIL tx_start_edge%0d: got %b expected %b", k, uart_tx, exp_line);
            end
        end
        repeat (32) @(posedge PCLK);
        #1;
        exp_rd.push_back(32'h0000_0006);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL tx_busy_end: got %h expected %h", rd, exp); end
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL tx_idle_after: got %h expected %h", rd, exp); end
        t = 0;
        while (got_tx.size() == 0 && t < 100) begin @(posedge PCLK); t++; end
        eb = exp_tx.pop_front();
        n_cmp++;
        if (got_tx.size() == 0) begin
            n_err++; $display("FAIL tx_frame: got no frame expected %h", {1'b1, eb});
        end else begin
            fr = got_tx.pop_front();
            if (fr !== {1'b1, eb}) begin n_err++; $display("FAIL tx_frame: got %h expected %h", fr, {1'b1, eb}); end
        end
    endtask

    task automatic test_tx_overflow;
        logic [31:0] rd, exp;
        logic [8:0]  fr;
        logic [7:0]  eb;
        int          t;
        for (int b = 1; b <= 6; b++) begin
            if (b <= 5) exp_tx.push_back(8'(b));
            apb_write(A_TX, 32'(b), 4'b0001);
        end
        exp_rd.push_back(32'h0000_0025);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovf_status: got %h expected %h", rd, exp); end
        apb_write(A_ST, 32'h0000_0020, 4'hF);
        exp_rd.push_back(32'h0000_0005);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovf_clear: got %h expected %h", rd, exp); end
        for (int n = 0; n < 5; n++) begin
            t = 0;
            while (got_tx.size() == 0 && t < 300) begin @(posedge PCLK); t++; end
            eb = exp_tx.pop_front();
            n_cmp++;
            if (got_tx.size() == 0) begin
                n_err++; $display("FAIL ovf_frame%0d: got no frame expected %h", n, {1'b1, eb});
            end else begin
                fr = got_tx.pop_front();
                if (fr !== {1'b1, eb}) begin n_err++; $display("FAIL ovf_frame%0d: got %h expected %h", n, fr, {1'b1, eb}); end
            end
        end
        repeat (60) @(posedge PCLK);
        #1;
        n_cmp++; if (got_tx.size() != 0) begin n_err++; $display("FAIL ovf_dropped: got %0d extra frames expected 0", got_tx.size()); end
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovf_idle: got %h expected %h", rd, exp); end
    endtask

    task automatic test_rx;
        logic [31:0] rd, exp;
        exp_rx.push_back(8'h3C);
        rx_send(8'h3C, 1'b1);
        repeat (4) @(posedge PCLK);
        #1;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rx_irq_set: got %b expected 1", irq); end
        exp_rd.push_back(32'h0000_000A);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rx_status_valid: got %h expected %h", rd, exp); end
        apb_read(A_RX, rd); exp = {24'h0, exp_rx.pop_front()};
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rx_data: got %h expected %h", rd, exp); end
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rx_status_cleared: got %h expected %h", rd, exp); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] rd, exp;
        exp_rx.push_back(8'h11);
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        repeat (4) @(posedge PCLK);
        #1;
        exp_rd.push_back(32'h0000_001A);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovr_status: got %h expected %h", rd, exp); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovr_irq: got %b expected 1", irq); end
        apb_read(A_RX, rd); exp = {24'h0, exp_rx.pop_front()};
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovr_data: got %h expected %h", rd, exp); end
        apb_write(A_ST, 32'h0000_0010, 4'b0001);
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ovr_clear: got %h expected %h", rd, exp); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ovr_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] rd, exp;
        @(posedge PCLK); #1 uart_rx = 1'b0;
        @(posedge PCLK); #1 uart_rx = 1'b1;
        repeat (20) @(posedge PCLK);
        #1;
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL glitch_status: got %h expected %h", rd, exp); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq: got %b expected 0", irq); end
        rx_send(8'h55, 1'b0);
        repeat (4) @(posedge PCLK);
        #1;
        exp_rd.push_back(32'h0000_0042);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ferr_status: got %h expected %h", rd, exp); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ferr_irq: got %b expected 1", irq); end
        apb_write(A_ST, 32'h0000_0040, 4'b0001);
        exp_rd.push_back(32'h0000_0002);
        apb_read(A_ST, rd); exp = exp_rd.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ferr_clear: got %h expected %h", rd, exp); end
        exp_rx.push_back(8'h5A);
        rx_send(8'h5A, 1'b1);
        repeat (4) @(posedge PCLK);
        #1;
        apb_read(A_RX, rd); exp = {24'h0, exp_rx.pop_front()};
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rx_recover: got %h expected %h", rd, exp); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_overflow();
        test_rx();
        test_rx_overrun();
        test_rx_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
